// File: rtl/fetch_stage.sv
// Instruction fetch stage: three-state request FSM toward instruction memory,
// one output register slot plus a one-entry skid buffer toward decode, and a
// drop flag that discards the response of a fetch made stale by a redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_if_o,
  output logic [31:0] pc_plus_4_if_o,
  output logic        valid_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        drop_q, drop_d;
  logic        out_vld_q, out_vld_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_pc4_q, out_pc4_d;
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;

  logic        fire;
  logic        resp_live;
  logic        consume;
  logic [31:0] redir_tgt;
  logic [31:0] resp_pc4;

  // Redirect targets are forced to word alignment.
  assign redir_tgt = redirect_pc_i & 32'hFFFF_FFFC;
  assign fire      = imem_req_o & imem_gnt_i;
  // Only a response in WAIT with no pending drop belongs to a live fetch;
  // anything arriving elsewhere predates a reset or a redirect.
  assign resp_live = (state_q == WAIT) & imem_rvalid_i & ~drop_q;
  assign consume   = out_vld_q & ~stall_i;
  assign resp_pc4  = fetch_pc_q + 32'd4;

  // FSM outputs: a request is withheld while a stale response is still due.
  always_comb begin
    imem_req_o  = (state_q == REQ) & ~drop_q;
    imem_addr_o = pc_q;
  end

  // FSM next state; redirect always forces a fresh request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!skid_vld_q) state_d = REQ;
      REQ:     if (fire) state_d = WAIT;
      WAIT:    if (imem_rvalid_i) state_d = skid_vld_d ? IDLE : REQ;
      default: state_d = IDLE;
    endcase
    if (redirect_i) state_d = REQ;
  end

  // Datapath: PC advance, output slot / skid management, drop flag.
  always_comb begin
    pc_d         = pc_q;
    fetch_pc_d   = fetch_pc_q;
    drop_d       = drop_q & ~imem_rvalid_i;
    out_vld_d    = out_vld_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    out_pc4_d    = out_pc4_q;
    skid_vld_d   = skid_vld_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_pc4_d   = skid_pc4_q;

    if (fire) begin
      fetch_pc_d = pc_q;
      pc_d       = pc_q + 32'd4;
    end

    // Decode took the current instruction: refill from skid or go empty.
    if (consume && skid_vld_q) begin
      out_vld_d   = 1'b1;
      out_instr_d = skid_instr_q;
      out_pc_d    = skid_pc_q;
      out_pc4_d   = skid_pc4_q;
      skid_vld_d  = 1'b0;
    end else if (consume) begin
      out_vld_d = 1'b0;
    end

    // A live response goes to the output slot if it frees up, else to skid.
    if (resp_live) begin
      if (!out_vld_q || (consume && !skid_vld_q)) begin
        out_vld_d   = 1'b1;
        out_instr_d = imem_rdata_i;
        out_pc_d    = fetch_pc_q;
        out_pc4_d   = resp_pc4;
      end else begin
        skid_vld_d   = 1'b1;
        skid_instr_d = imem_rdata_i;
        skid_pc_d    = fetch_pc_q;
        skid_pc4_d   = resp_pc4;
      end
    end

    // Redirect wins over everything, stall included.
    if (redirect_i) begin
      pc_d       = redir_tgt;
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
      if (((state_q == WAIT) && !imem_rvalid_i) || fire) drop_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      fetch_pc_q   <= '0;
      drop_q       <= 1'b0;
      out_vld_q    <= 1'b0;
      out_instr_q  <= '0;
      out_pc_q     <= '0;
      out_pc4_q    <= '0;
      skid_vld_q   <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_pc_q   <= fetch_pc_d;
      drop_q       <= drop_d;
      out_vld_q    <= out_vld_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      out_pc4_q    <= out_pc4_d;
      skid_vld_q   <= skid_vld_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

  assign valid_o        = out_vld_q;
  assign instruction_o  = out_instr_q;
  assign pc_if_o        = out_pc_q;
  assign pc_plus_4_if_o = out_pc4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a randomized memory model plus a PC-stream
// scoreboard (program order from the last reset/redirect target), with a
// second instance built at RESET_PC=0xFFFF_FFFC for the wrap case.
module tb_fetch_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i, valid_o;
  logic [31:0] imem_addr_o, imem_rdata_i, instruction_o, pc_if_o, pc_plus_4_if_o;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instruction_o(instruction_o), .pc_if_o(pc_if_o), .pc_plus_4_if_o(pc_plus_4_if_o),
    .valid_o(valid_o));

  logic        rst2_n, stall2, redir2, req2, gnt2, rvalid2, valid2;
  logic [31:0] rpc2, addr2, rdata2, instr2, pc2, pc42;

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst2_n), .stall_i(stall2), .redirect_i(redir2),
    .redirect_pc_i(rpc2), .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_gnt_i(gnt2), .imem_rvalid_i(rvalid2), .imem_rdata_i(rdata2),
    .instruction_o(instr2), .pc_if_o(pc2), .pc_plus_4_if_o(pc42),
    .valid_o(valid2));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Scoreboard: expected PCs in program order from the current base.
  logic [31:0] exp_q[$];
  logic [31:0] next_push;

  task automatic sb_fill();
    while (exp_q.size() < 16) begin
      exp_q.push_back(next_push);
      next_push += 32'd4;
    end
  endtask

  task automatic sb_reset(input logic [31:0] base);
    exp_q.delete();
    next_push = base;
    sb_fill();
  endtask

  // Memory model / stimulus state.
  int          gnt_pct = 100, lat_lo = 1, lat_hi = 1;
  bit          pend = 0, pend_stale = 0;
  int          pcnt = 0;
  logic [31:0] paddr = '0;
  int          ngnt = 0, cyc = 0, npop = 0, nv = 0;
  int          vcyc[4];
  logic [31:0] exp_fetch = '0;
  logic        rst_next = 1'b0;
  bit          prev_req = 0, prev_gnt = 0, prev_rd = 0, prev_rst = 0;
  logic [31:0] prev_addr = '0;

  // One clock of stimulus, driven at the falling edge.
  task automatic step(input bit st, input bit rd, input logic [31:0] tgt);
    @(negedge clk);
    cyc++;
    rst_n         = rst_next;
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = rd ? tgt : $urandom;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = $urandom;
    if (pend) begin
      if (pcnt <= 1) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = word_at(paddr);
        pend          = 0;
        pend_stale    = 0;
      end else pcnt--;
    end
    if (rst_n && prev_rst && prev_req && !prev_gnt && !prev_rd) begin
      chk("req_hold", {31'd0, imem_req_o}, 32'd1);
      chk("addr_hold", imem_addr_o, prev_addr);
    end
    if (rst_n && prev_rst && prev_rd && imem_req_o)
      chk("redir_addr", imem_addr_o, exp_fetch);
    if (rst_n && pend && !pend_stale)
      chk("one_outstanding", {31'd0, imem_req_o}, 32'd0);
    imem_gnt_i = 1'b0;
    if (rst_n && imem_req_o && !pend && ($urandom_range(99) < gnt_pct)) begin
      imem_gnt_i = 1'b1;
      pend       = 1;
      pend_stale = 0;
      pcnt       = int'($urandom_range(lat_hi, lat_lo));
      paddr      = imem_addr_o;
      ngnt++;
      chk("fetch_addr", imem_addr_o, exp_fetch);
      exp_fetch += 32'd4;
    end
    if (rd) begin
      exp_fetch = {tgt[31:2], 2'b00};
      sb_reset(exp_fetch);
    end
    sb_fill();
    prev_req  = imem_req_o;
    prev_addr = imem_addr_o;
    prev_gnt  = imem_gnt_i;
    prev_rd   = rd;
    prev_rst  = rst_n;
  endtask

  // Monitor: every instruction decode accepts must be the next expected PC.
  initial begin : mon
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && valid_o && !stall_i && !redirect_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty: got pc %h with nothing expected", pc_if_o);
        end else begin
          e = exp_q.pop_front();
          chk("pc_if", pc_if_o, e);
          chk("instr", instruction_o, word_at(e));
          chk("pc_plus_4", pc_plus_4_if_o, e + 32'd4);
          npop++;
          if (nv < 4) begin
            vcyc[nv] = cyc;
            nv++;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1);
  end

  // Main sequence.
  initial begin : main
    int guard, req_cyc, g0, p0;
    logic [31:0] hold_i, hold_pc;
    rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    sb_reset(32'h0);
    repeat (2) step(0, 0, 0);
    #1;
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_instr", instruction_o, 32'd0);
    chk("rst_pc", pc_if_o, 32'd0);
    chk("rst_pc4", pc_plus_4_if_o, 32'd0);
    chk("rst_addr", imem_addr_o, 32'd0);

    // Zero-wait memory after reset release: 1 instr / 2 cycles.
    rst_next = 1'b1;
    nv = 0;
    step(0, 0, 0);
    step(0, 0, 0);
    chk("first_req", {31'd0, imem_req_o}, 32'd1);
    chk("first_addr", imem_addr_o, 32'd0);
    req_cyc = cyc;
    repeat (8) step(0, 0, 0);
    chk("lat_first", vcyc[0] - req_cyc, 32'd2);
    chk("rate_1", vcyc[1] - vcyc[0], 32'd2);
    chk("rate_2", vcyc[2] - vcyc[1], 32'd2);

    // Six-cycle stall: output held, skid fills once, no further request.
    guard = 0;
    do begin step(0, 0, 0); guard++; end while (!valid_o && guard < 10);
    step(0, 0, 0);
    g0 = ngnt;
    step(1, 0, 0);
    chk("stall_valid0", {31'd0, valid_o}, 32'd1);
    hold_i  = instruction_o;
    hold_pc = pc_if_o;
    chk("stall_front", hold_pc, exp_q[0]);
    repeat (5) begin
      step(1, 0, 0);
      chk("stall_valid", {31'd0, valid_o}, 32'd1);
      chk("stall_instr", instruction_o, hold_i);
      chk("stall_pc", pc_if_o, hold_pc);
    end
    chk("stall_gnts", ngnt - g0, 32'd1);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("skid_valid", {31'd0, valid_o}, 32'd1);
    chk("skid_pc", pc_if_o, hold_pc + 32'd4);

    // Redirect while waiting on a 3-cycle response.
    lat_lo = 3; lat_hi = 3;
    g0 = ngnt; guard = 0;
    do begin step(0, 0, 0); guard++; end while (ngnt == g0 && guard < 20);
    step(0, 1, 32'h100);
    p0 = npop;
    repeat (25) step(0, 0, 0);
    chk("redir_wait_live", {31'd0, npop > p0}, 32'd1);

    // Redirect to an unaligned target while decode stalls on a valid output.
    lat_lo = 1; lat_hi = 1;
    guard = 0;
    do begin step(1, 0, 0); guard++; end while (!valid_o && guard < 20);
    step(1, 1, 32'h203);
    step(1, 0, 0);
    chk("redir_kill", {31'd0, valid_o}, 32'd0);
    chk("redir_aligned", imem_addr_o, 32'h200);
    p0 = npop;
    repeat (12) step(0, 0, 0);
    chk("redir_stall_live", {31'd0, npop > p0}, 32'd1);

    // Randomized traffic.
    gnt_pct = 70; lat_lo = 1; lat_hi = 4;
    p0 = npop;
    for (int i = 0; i < 1500; i++)
      step($urandom_range(99) < 30, $urandom_range(99) < 3, $urandom);
    chk("rand_live", {31'd0, (npop - p0) > 50}, 32'd1);

    // Reset pulse while a 4-cycle fetch is outstanding.
    gnt_pct = 100; lat_lo = 4; lat_hi = 4;
    repeat (6) step(0, 0, 0);
    g0 = ngnt; guard = 0;
    do begin step(0, 0, 0); guard++; end while (ngnt == g0 && guard < 20);
    step(0, 0, 0);
    rst_next = 1'b0;
    step(0, 0, 0);
    pend_stale = pend;
    #1;
    chk("rst2_valid", {31'd0, valid_o}, 32'd0);
    chk("rst2_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst2_instr", instruction_o, 32'd0);
    chk("rst2_pc4", pc_plus_4_if_o, 32'd0);
    chk("rst2_addr", imem_addr_o, 32'd0);
    rst_next = 1'b1;
    step(0, 0, 0);
    exp_fetch = 32'h0;
    sb_reset(32'h0);
    p0 = npop;
    repeat (25) step(0, 0, 0);
    chk("rst_restart_live", {31'd0, npop > p0}, 32'd1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Second instance: reset PC at the top of the address space.
  initial begin : wrap
    bit          pend2, seen2;
    logic [31:0] paddr2;
    logic [31:0] ga2[2];
    int          ng2;
    pend2 = 0; seen2 = 0; paddr2 = '0; ng2 = 0; ga2[0] = '1; ga2[1] = '1;
    rst2_n = 1'b0; stall2 = 1'b0; redir2 = 1'b0; rpc2 = '0;
    gnt2 = 1'b0; rvalid2 = 1'b0; rdata2 = '0;
    repeat (3) @(negedge clk);
    #3 rst2_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #3;
      rvalid2 = pend2;
      rdata2  = paddr2;
      pend2   = 0;
      gnt2    = 1'b0;
      if (req2) begin
        gnt2   = 1'b1;
        pend2  = 1;
        paddr2 = addr2;
        if (ng2 < 2) ga2[ng2] = addr2;
        ng2++;
      end
      if (valid2 && !seen2) begin
        seen2 = 1;
        chk("wrap_pc", pc2, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc42, 32'h0000_0000);
        chk("wrap_instr", instr2, 32'hFFFF_FFFC);
      end
    end
    chk("wrap_seen", {31'd0, seen2}, 32'd1);
    chk("wrap_addr0", ga2[0], 32'hFFFF_FFFC);
    chk("wrap_addr1", ga2[1], 32'h0000_0000);
  end

endmodule
